// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with optional shift-add multiply (enable macro: ALU_SEQ_MUL_EN)
module alu_seq #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] valD,
   input  logic [WIDTH-1:0] regT,
   output logic [WIDTH-1:0] alu_out,
   output logic             regF,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_SHL  = 3'b000;
   localparam logic [2:0] OP_SHL1 = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ITER = 1'b1
   } state_t;
`else
   typedef enum logic {
      S_IDLE = 1'b0
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic             flag_q, flag_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;

`ifdef ALU_SEQ_MUL_EN
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     step_sum;
`endif

   // Carry and borrow fall out of the extra top bit of a WIDTH+1 wide add/subtract.
   assign add_sum  = {1'b0, valD} + {1'b0, regT};
   assign sub_diff = {1'b0, valD} - {1'b0, regT};

   // Next-state logic: single-cycle ops resolve in IDLE, multiply walks one multiplier bit per ITER cycle.
   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      flag_d  = flag_q;
      done_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      step_sum = {(WIDTH+1){1'b0}};
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d = 1'b1;
               case (select)
                  OP_SHL: begin
                     alu_d  = {regT[WIDTH-2:0], 1'b0};
                     flag_d = regT[WIDTH-1];
                  end
                  OP_SHL1: begin
                     alu_d  = {regT[WIDTH-2:0], 1'b1};
                     flag_d = regT[WIDTH-1];
                  end
                  OP_LOAD: begin
                     alu_d  = valD;
                     flag_d = 1'b0;
                  end
                  OP_SUB: begin
                     alu_d  = sub_diff[WIDTH-1:0];
                     flag_d = sub_diff[WIDTH];
                  end
                  OP_ADD: begin
                     alu_d  = add_sum[WIDTH-1:0];
                     flag_d = add_sum[WIDTH];
                  end
`ifdef ALU_SEQ_MUL_EN
                  OP_MUL: begin
                     // Operands are frozen here so later input changes cannot leak into the product.
                     done_d  = 1'b0;
                     busy_d  = 1'b1;
                     state_d = S_ITER;
                     cnt_d   = {CNT_W{1'b0}};
                     mcand_d = valD;
                     prod_d  = {{WIDTH{1'b0}}, regT};
                  end
`endif
                  default: begin
                     alu_d  = valD;
                     flag_d = 1'b0;
                  end
               endcase
            end
         end
`ifdef ALU_SEQ_MUL_EN
         S_ITER: begin
            // Low half holds the unconsumed multiplier bits; the sum shifts in from the top.
            step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
            prod_d   = {step_sum, prod_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               alu_d   = prod_d[WIDTH-1:0];
               flag_d  = |prod_d[2*WIDTH-1:WIDTH];
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset clears everything at once and discards any running multiply.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         alu_q   <= {WIDTH{1'b0}};
         flag_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         busy_q  <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         mcand_q <= {WIDTH{1'b0}};
         prod_q  <= {(2*WIDTH){1'b0}};
`endif
      end else begin
         state_q <= state_d;
         alu_q   <= alu_d;
         flag_q  <= flag_d;
         done_q  <= done_d;
`ifdef ALU_SEQ_MUL_EN
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
`endif
      end
   end

   assign alu_out = alu_q;
   assign regF    = flag_q;
   assign done    = done_q;
`ifdef ALU_SEQ_MUL_EN
   assign busy    = busy_q;
`else
   assign busy    = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 3: operand/result width in bits, legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  op request; sampled only in IDLE.
REQ-005 SHALL have port select  input  3  opcode, captured at accepted start.
REQ-006 SHALL have port valD  input  WIDTH  data operand D, captured at accepted start.
REQ-007 SHALL have port regT  input  WIDTH  top-of-stack operand T, captured at accepted start.
REQ-008 SHALL have port alu_out  output  WIDTH  registered result.
REQ-009 SHALL have port regF  output  1  registered flag (carry/borrow/overflow).
REQ-010 SHALL have port busy  output  1  high while a multi-cycle op is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when alu_out/regF update.

Function
REQ-012 SHALL implement FSM states IDLE, ITER; start=1 in IDLE is "accepted".
REQ-013 SHALL, for single-cycle ops, update alu_out/regF and pulse done at the edge that accepts start (latency 1), staying in IDLE.
REQ-014 SHALL implement 000: alu_out = T<<1 (mod 2^WIDTH), regF = T[WIDTH-1].
REQ-015 SHALL implement 001: alu_out = (T<<1)|1 (mod 2^WIDTH), regF = T[WIDTH-1].
REQ-016 SHALL implement 010: alu_out = D, regF = 0.
REQ-017 SHALL implement 011: alu_out = D-T mod 2^WIDTH, regF = 1 iff D<T (unsigned).
REQ-018 SHALL implement 100: alu_out = D+T mod 2^WIDTH, regF = carry out of bit WIDTH-1.
REQ-019 SHALL treat 110, 111 (and 101 when multiply is compiled out) as reserved: alu_out = D, regF = 0, latency 1.
REQ-020 SHALL implement 101 (multiply, see Configuration) as shift-add: accepted start -> ITER, exactly WIDTH cycles in ITER, then IDLE with done pulse; latency WIDTH+1 edges from acceptance.
REQ-021 SHALL, for 101, produce alu_out = low WIDTH bits of D*T, regF = 1 iff high WIDTH bits of 2*WIDTH-bit product nonzero.
REQ-022 SHALL drive busy=1 exactly while in ITER; busy and done never both high.
REQ-023 SHALL ignore start, select, valD, regT while in ITER; operand changes after acceptance SHALL NOT affect result.
REQ-024 SHALL hold alu_out and regF unchanged between done pulses (including during ITER).
REQ-025 SHALL accept a new start in the cycle IDLE is re-entered after multiply completion, i.e. back-to-back ops with no gap.
REQ-026 SHALL keep an internal iteration counter of ceil(log2(WIDTH+1)) bits, reset to 0 on every acceptance.

Reset
REQ-027 SHALL, on rst=1, immediately force state IDLE, alu_out=0, regF=0, busy=0, done=0, counter and partial product 0.
REQ-028 SHALL abort an in-progress multiply on rst with no done pulse and no result update.
REQ-029 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL compile opcode 101 multiply, ITER state, counter and product register only when macro ALU_SEQ_MUL_EN is defined.
REQ-031 SHALL, without ALU_SEQ_MUL_EN, treat 101 as reserved (REQ-019), tie busy to 0, and contain no ITER state.

Verification
REQ-032 SHALL cover: WIDTH=3, select=011, D=2, T=5, start 1 cycle -> next edge alu_out=5, regF=1, done=1 for 1 cycle.
REQ-033 SHALL cover: WIDTH=3, select=001, T=6 -> alu_out=5, regF=1; select=000, T=3 -> alu_out=6, regF=0.
REQ-034 SHALL cover: WIDTH=3, select=100, D=7, T=1 -> alu_out=0, regF=1; then select=010, D=4 -> alu_out=4, regF=0.
REQ-035 SHALL cover (ALU_SEQ_MUL_EN): WIDTH=3, select=101, D=3, T=5 -> busy=1 for 3 cycles, operands toggled during ITER ignored, done at edge 4, alu_out=7, regF=1.
REQ-036 SHALL cover (ALU_SEQ_MUL_EN): rst asserted in second ITER cycle -> all outputs 0 at once, no done; next start D=2, T=2, select=101 -> alu_out=4, regF=0.
REQ-037 SHALL cover: WIDTH=8 build, select=011, D=0x10, T=0x11 -> alu_out=0xFF, regF=1; without macro, select=101 -> alu_out=D, busy stays 0.
